// File: rtl/redmule_tiling_engine_if.sv
// Request/result bundle between the RedMulE register file and the tiling engine.
// The engine uses the slave view; the register-file side uses the master view.
interface redmule_tiling_engine_if;
  logic        clear_i;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic [15:0] m_size_i;
  logic [15:0] n_size_i;
  logic [15:0] k_size_i;
  logic [1:0]  fmt_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] x_rows_iter_o;
  logic [15:0] x_cols_iter_o;
  logic [15:0] w_rows_iter_o;
  logic [15:0] w_cols_iter_o;
  logic [7:0]  x_rows_lftovr_o;
  logic [7:0]  x_cols_lftovr_o;
  logic [7:0]  w_rows_lftovr_o;
  logic [7:0]  w_cols_lftovr_o;
  logic [31:0] x_d1_stride_o;
  logic [31:0] yz_d0_stride_o;
  logic [31:0] tot_stores_o;
  logic [31:0] x_tot_len_o;
  logic        err_o;
  logic        ovf_o;

  modport slave (
    input  clear_i, cfg_valid_i, m_size_i, n_size_i, k_size_i, fmt_i, out_ready_i,
    output cfg_ready_o, out_valid_o,
    output x_rows_iter_o, x_cols_iter_o, w_rows_iter_o, w_cols_iter_o,
    output x_rows_lftovr_o, x_cols_lftovr_o, w_rows_lftovr_o, w_cols_lftovr_o,
    output x_d1_stride_o, yz_d0_stride_o, tot_stores_o, x_tot_len_o, err_o, ovf_o
  );

  modport master (
    output clear_i, cfg_valid_i, m_size_i, n_size_i, k_size_i, fmt_i, out_ready_i,
    input  cfg_ready_o, out_valid_o,
    input  x_rows_iter_o, x_cols_iter_o, w_rows_iter_o, w_cols_iter_o,
    input  x_rows_lftovr_o, x_cols_lftovr_o, w_rows_lftovr_o, w_cols_lftovr_o,
    input  x_d1_stride_o, yz_d0_stride_o, tot_stores_o, x_tot_len_o, err_o, ovf_o
  );
endinterface

// File: rtl/redmule_tiling_engine.sv
// Sequential tiling-parameter generator: derives iteration counts, leftovers, strides
// and totals from raw GEMM sizes using shifts/masks and a radix-2 shift-add multiplier.
module redmule_tiling_engine #(
  parameter int DATA_W       = 256,
  parameter int ARRAY_HEIGHT = 8,
  parameter int PIPE_REGS    = 1
) (
  input logic clk_i,
  input logic rst_i,
  redmule_tiling_engine_if.slave bus
);

  localparam int          ARRAY_WIDTH = ARRAY_HEIGHT * PIPE_REGS;
  localparam logic [4:0]  AW_LOG      = 5'($clog2(ARRAY_WIDTH));
  localparam logic [15:0] AW_MASK     = 16'(ARRAY_WIDTH - 1);
  localparam logic [4:0]  AH_LOG      = 5'($clog2(ARRAY_HEIGHT));
  localparam logic [15:0] AH_MASK     = 16'(ARRAY_HEIGHT - 1);
  localparam logic [4:0]  D_LOG8      = 5'($clog2(DATA_W) - 3);
  localparam logic [4:0]  D_LOG16     = 5'($clog2(DATA_W) - 4);

  typedef enum logic [2:0] {IDLE, PREP, MUL1, MUL2, DONE} state_e;

  state_e      state;
  logic [15:0] m_q, n_q, k_q;
  logic        e16_q;
  logic [3:0]  cnt;
  logic [47:0] mcand, acc;
  logic [15:0] mplier;

  logic        ready_q, valid_q, err_q, ovf_q;
  logic [15:0] xri_q, xci_q, wri_q, wci_q;
  logic [7:0]  xrl_q, xcl_q, wrl_q, wcl_q;
  logic [31:0] xs_q, ys_q, ts_q, tl_q;

  logic        unused_fmt;
  logic [4:0]  d_log;
  logic [15:0] d_mask;
  logic [15:0] xri_c, xci_c, wri_c, wci_c;
  logic [31:0] xs_c, ys_c;
  logic        zero_c;
  logic [47:0] acc_next;

  assign unused_fmt = bus.fmt_i[1];

  // Ceil-divisions are shift plus a remainder-nonzero bit, so they never overflow.
  always_comb begin
    d_log    = e16_q ? D_LOG16 : D_LOG8;
    d_mask   = (16'd1 << d_log) - 16'd1;
    xri_c    = (m_q >> AW_LOG) + {15'd0, |(m_q & AW_MASK)};
    xci_c    = (n_q >> d_log)  + {15'd0, |(n_q & d_mask)};
    wri_c    = (n_q >> AH_LOG) + {15'd0, |(n_q & AH_MASK)};
    wci_c    = (k_q >> d_log)  + {15'd0, |(k_q & d_mask)};
    xs_c     = {16'd0, n_q} << e16_q;
    ys_c     = {16'd0, k_q} << e16_q;
    zero_c   = (m_q == 16'd0) || (n_q == 16'd0) || (k_q == 16'd0);
    acc_next = acc + (mplier[0] ? mcand : 48'd0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || bus.clear_i) begin
      state   <= IDLE;
      m_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      e16_q   <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      xri_q   <= '0;
      xci_q   <= '0;
      wri_q   <= '0;
      wci_q   <= '0;
      xrl_q   <= '0;
      xcl_q   <= '0;
      wrl_q   <= '0;
      wcl_q   <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      ts_q    <= '0;
      tl_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cfg_valid_i) begin
            m_q     <= bus.m_size_i;
            n_q     <= bus.n_size_i;
            k_q     <= bus.k_size_i;
            e16_q   <= bus.fmt_i[0];
            ready_q <= 1'b0;
            state   <= PREP;
          end
        end
        PREP: begin
          ovf_q <= 1'b0;
          ts_q  <= '0;
          tl_q  <= '0;
          if (zero_c) begin
            err_q   <= 1'b1;
            xri_q   <= '0;
            xci_q   <= '0;
            wri_q   <= '0;
            wci_q   <= '0;
            xrl_q   <= '0;
            xcl_q   <= '0;
            wrl_q   <= '0;
            wcl_q   <= '0;
            xs_q    <= '0;
            ys_q    <= '0;
            valid_q <= 1'b1;
            state   <= DONE;
          end else begin
            err_q  <= 1'b0;
            xri_q  <= xri_c;
            xci_q  <= xci_c;
            wri_q  <= wri_c;
            wci_q  <= wci_c;
            xrl_q  <= 8'(m_q & AW_MASK);
            xcl_q  <= 8'(n_q & d_mask);
            wrl_q  <= 8'(n_q & AH_MASK);
            wcl_q  <= 8'(k_q & d_mask);
            xs_q   <= xs_c;
            ys_q   <= ys_c;
            mcand  <= {32'd0, xri_c};
            mplier <= wci_c;
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL1;
          end
        end
        // Both multiplies walk all 16 multiplier bits so latency is data-independent.
        MUL1: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            ts_q   <= acc_next[31:0];
            mcand  <= {16'd0, acc_next[31:0]};
            mplier <= xci_q;
            acc    <= '0;
            state  <= MUL2;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
        MUL2: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            tl_q    <= acc_next[31:0];
            ovf_q   <= |acc_next[47:32];
            valid_q <= 1'b1;
            state   <= DONE;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
        DONE: begin
          if (bus.out_ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cfg_ready_o     = ready_q;
  assign bus.out_valid_o     = valid_q;
  assign bus.err_o           = err_q;
  assign bus.ovf_o           = ovf_q;
  assign bus.x_rows_iter_o   = xri_q;
  assign bus.x_cols_iter_o   = xci_q;
  assign bus.w_rows_iter_o   = wri_q;
  assign bus.w_cols_iter_o   = wci_q;
  assign bus.x_rows_lftovr_o = xrl_q;
  assign bus.x_cols_lftovr_o = xcl_q;
  assign bus.w_rows_lftovr_o = wrl_q;
  assign bus.w_cols_lftovr_o = wcl_q;
  assign bus.x_d1_stride_o   = xs_q;
  assign bus.yz_d0_stride_o  = ys_q;
  assign bus.tot_stores_o    = ts_q;
  assign bus.x_tot_len_o     = tl_q;

endmodule

// File: tb/tb_redmule_tiling_engine.sv
// Directed table-driven bench for redmule_tiling_engine with default parameters
// (DATA_W=256, ARRAY_HEIGHT=8, PIPE_REGS=1), plus hand-written control sequences.
module tb_redmule_tiling_engine;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  redmule_tiling_engine_if bus();

  redmule_tiling_engine dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] m, n, k;
    logic [1:0]  fmt;
    logic [15:0] xri, xci, wri, wci;
    logic [7:0]  xrl, xcl, wrl, wcl;
    logic [31:0] xs, ys, ts, tl;
    logic        err, ovf;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input vec_t v);
    check("x_rows_iter", 32'(bus.x_rows_iter_o), 32'(v.xri));
    check("x_cols_iter", 32'(bus.x_cols_iter_o), 32'(v.xci));
    check("w_rows_iter", 32'(bus.w_rows_iter_o), 32'(v.wri));
    check("w_cols_iter", 32'(bus.w_cols_iter_o), 32'(v.wci));
    check("x_rows_lftovr", 32'(bus.x_rows_lftovr_o), 32'(v.xrl));
    check("x_cols_lftovr", 32'(bus.x_cols_lftovr_o), 32'(v.xcl));
    check("w_rows_lftovr", 32'(bus.w_rows_lftovr_o), 32'(v.wrl));
    check("w_cols_lftovr", 32'(bus.w_cols_lftovr_o), 32'(v.wcl));
    check("x_d1_stride", bus.x_d1_stride_o, v.xs);
    check("yz_d0_stride", bus.yz_d0_stride_o, v.ys);
    check("tot_stores", bus.tot_stores_o, v.ts);
    check("x_tot_len", bus.x_tot_len_o, v.tl);
    check("err", 32'(bus.err_o), 32'(v.err));
    check("ovf", 32'(bus.ovf_o), 32'(v.ovf));
  endtask

  // Drives one request at a negedge; cycles counts posedges including the accepting one.
  task automatic apply_stimulus(input vec_t v, output int cycles);
    @(negedge clk);
    check("cfg_ready_before", 32'(bus.cfg_ready_o), 32'd1);
    bus.cfg_valid_i = 1'b1;
    bus.m_size_i    = v.m;
    bus.n_size_i    = v.n;
    bus.k_size_i    = v.k;
    bus.fmt_i       = v.fmt;
    @(posedge clk);
    cycles = 1;
    @(negedge clk);
    bus.cfg_valid_i = 1'b0;
    while (!bus.out_valid_o && cycles < 100) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic run_vector(input vec_t v, input bit early_ready);
    int cycles;
    bus.out_ready_i = early_ready;
    apply_stimulus(v, cycles);
    check("latency", 32'(cycles), 32'(v.lat));
    check("out_valid", 32'(bus.out_valid_o), 32'd1);
    check_outputs(v);
    if (!early_ready) begin
      check("cfg_ready_done", 32'(bus.cfg_ready_o), 32'd0);
      bus.out_ready_i = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    check("out_valid_after", 32'(bus.out_valid_o), 32'd0);
    check("cfg_ready_after", 32'(bus.cfg_ready_o), 32'd1);
    check_outputs(v);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_cfg_ready"}, 32'(bus.cfg_ready_o), 32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid_o), 32'd0);
    check({tag, "_x_rows_iter"}, 32'(bus.x_rows_iter_o), 32'd0);
    check({tag, "_w_cols_lftovr"}, 32'(bus.w_cols_lftovr_o), 32'd0);
    check({tag, "_x_d1_stride"}, bus.x_d1_stride_o, 32'd0);
    check({tag, "_tot_stores"}, bus.tot_stores_o, 32'd0);
    check({tag, "_x_tot_len"}, bus.x_tot_len_o, 32'd0);
    check({tag, "_err"}, 32'(bus.err_o), 32'd0);
    check({tag, "_ovf"}, 32'(bus.ovf_o), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    logic [31:0] held_len;
    checks = 0;
    errors = 0;

    //         m      n      k      fmt   xri    xci    wri    wci    xrl xcl wrl wcl xs      ys      ts        tl   err  ovf  lat
    vecs[0] = '{16'd20, 16'd33, 16'd40, 2'd1, 16'd3, 16'd3, 16'd5, 16'd3, 8'd4, 8'd1, 8'd1, 8'd8,
                32'd66, 32'd80, 32'd9, 32'd27, 1'b0, 1'b0, 34};
    vecs[1] = '{16'd8, 16'd32, 16'd64, 2'd0, 16'd1, 16'd1, 16'd4, 16'd2, 8'd0, 8'd0, 8'd0, 8'd0,
                32'd32, 32'd64, 32'd2, 32'd2, 1'b0, 1'b0, 34};
    vecs[2] = '{16'd65535, 16'd65535, 16'd65535, 2'd0, 16'd8192, 16'd2048, 16'd8192, 16'd2048,
                8'd7, 8'd31, 8'd7, 8'd31, 32'd65535, 32'd65535, 32'd16777216, 32'd0, 1'b0, 1'b1, 34};
    vecs[3] = '{16'd0, 16'd5, 16'd5, 2'd0, 16'd0, 16'd0, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 2};
    vecs[4] = '{16'd65535, 16'd65535, 16'd65535, 2'd3, 16'd8192, 16'd4096, 16'd8192, 16'd4096,
                8'd7, 8'd15, 8'd7, 8'd15, 32'd131070, 32'd131070, 32'd33554432, 32'd0, 1'b0, 1'b1, 34};
    vecs[5] = '{16'd100, 16'd200, 16'd300, 2'd2, 16'd13, 16'd7, 16'd25, 16'd10, 8'd4, 8'd8, 8'd0, 8'd12,
                32'd200, 32'd300, 32'd130, 32'd910, 1'b0, 1'b0, 34};
    vecs[6] = '{16'd17, 16'd1, 16'd1, 2'd3, 16'd3, 16'd1, 16'd1, 16'd1, 8'd1, 8'd1, 8'd1, 8'd1,
                32'd2, 32'd2, 32'd3, 32'd3, 1'b0, 1'b0, 34};

    rst             = 1'b1;
    bus.clear_i     = 1'b0;
    bus.cfg_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.m_size_i    = '0;
    bus.n_size_i    = '0;
    bus.k_size_i    = '0;
    bus.fmt_i       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < 7; i++) run_vector(vecs[i], (i % 2) == 1);

    $display("[TB] back-to-back with out_ready held high");
    run_vector(vecs[0], 1'b1);
    run_vector(vecs[5], 1'b1);

    $display("[TB] backpressure");
    bus.out_ready_i = 1'b0;
    apply_stimulus(vecs[0], cycles);
    check("bp_latency", 32'(cycles), 32'd34);
    held_len = bus.x_tot_len_o;
    check("bp_x_tot_len", held_len, 32'd27);
    bus.cfg_valid_i = 1'b1;
    bus.m_size_i    = 16'd1000;
    bus.n_size_i    = 16'd1000;
    bus.k_size_i    = 16'd1000;
    bus.fmt_i       = 2'd0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid_o), 32'd1);
      check("bp_cfg_ready", 32'(bus.cfg_ready_o), 32'd0);
      check("bp_hold_len", bus.x_tot_len_o, 32'd27);
    end
    bus.cfg_valid_i = 1'b0;
    check_outputs(vecs[0]);
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    check("bp_idle_ready", 32'(bus.cfg_ready_o), 32'd1);
    check("bp_idle_valid", 32'(bus.out_valid_o), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bp_ignored_valid", 32'(bus.out_valid_o), 32'd0);
    check_outputs(vecs[0]);

    $display("[TB] clear during MUL1");
    @(negedge clk);
    bus.cfg_valid_i = 1'b1;
    bus.m_size_i    = vecs[1].m;
    bus.n_size_i    = vecs[1].n;
    bus.k_size_i    = vecs[1].k;
    bus.fmt_i       = vecs[1].fmt;
    @(posedge clk);
    @(negedge clk);
    bus.cfg_valid_i = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("clr_busy", 32'(bus.cfg_ready_o), 32'd0);
    bus.clear_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.clear_i = 1'b0;
    check_cleared("clear");

    $display("[TB] reset during MUL2");
    @(negedge clk);
    bus.cfg_valid_i = 1'b1;
    bus.m_size_i    = vecs[2].m;
    bus.n_size_i    = vecs[2].n;
    bus.k_size_i    = vecs[2].k;
    bus.fmt_i       = vecs[2].fmt;
    @(posedge clk);
    @(negedge clk);
    bus.cfg_valid_i = 1'b0;
    repeat (25) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.cfg_ready_o), 32'd0);
    check("rst_partial_iter", 32'(bus.x_rows_iter_o), 32'd8192);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_cleared("midreset");
    run_vector(vecs[0], 1'b0);

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/redmule_tiling_engine.md
Name: redmule_tiling_engine

Overview:
- Sequential tiling-parameter generator for the RedMulE controller.
- Takes raw GEMM sizes M, N, K and the element format from the slave register file.
- Computes the final register-file tiling fields: iterations, leftovers, strides, total stores and total X reads.
- Parametrised in datapath width and array geometry, supports 8- and 16-bit element formats, and replaces hard-coded software precomputation. Uses a shift-add multiplier instead of DSP multipliers.

Parameters:
- DATA_W, 256: TCDM beat width in bits. Power of two, ≥ 128.
- ARRAY_HEIGHT, 8: number of CE columns per row. Power of two.
- PIPE_REGS, 1: CE pipeline registers. ARRAY_WIDTH = ARRAY_HEIGHT*PIPE_REGS must be a power of two.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active high
- clear_i  in  1  synchronous abort to IDLE
- cfg_valid_i  in  1  request valid
- cfg_ready_o  out  1  high only in IDLE
- m_size_i  in  16  X/Z rows
- n_size_i  in  16  X cols / W rows
- k_size_i  in  16  W/Z cols
- fmt_i  in  2  gemm_fmt_e: 0/2 = 8-bit elements, 1/3 = 16-bit elements
- out_valid_o  out  1  results valid
- out_ready_i  in  1  consumer accepts results
- x_rows_iter_o, x_cols_iter_o, w_rows_iter_o, w_cols_iter_o  out  16 each
- x_rows_lftovr_o, x_cols_lftovr_o, w_rows_lftovr_o, w_cols_lftovr_o  out  8 each
- x_d1_stride_o, yz_d0_stride_o, tot_stores_o, x_tot_len_o  out  32 each
- err_o  out  1  zero size given
- ovf_o  out  1  x_tot_len truncated

Behaviour:
- Reset (rst_i async): state IDLE, all outputs and registers 0, cfg_ready_o=1.
- FSM states: IDLE → PREP → MUL1 → MUL2 → DONE → IDLE.
- IDLE: on cfg_valid_i&cfg_ready_o, capture M, N, K and fmt; go to PREP.
- Derived values: E = 8 or 16 per fmt; D = DATA_W/E; AW = ARRAY_WIDTH. All divides and mods are shifts/masks.
- PREP (1 cycle):
  - If any size is 0: err_o=1, all numeric outputs 0, go to DONE.
  - Otherwise register:
    - x_rows_iter = ceil(M/AW), x_rows_lftovr = M mod AW
    - x_cols_iter = ceil(N/D), x_cols_lftovr = N mod D
    - w_rows_iter = ceil(N/ARRAY_HEIGHT), w_rows_lftovr = N mod ARRAY_HEIGHT
    - w_cols_iter = ceil(K/D), w_cols_lftovr = K mod D
    - x_d1_stride = N*E/8 bytes; yz_d0_stride = K*E/8 bytes
  - Ceil-division must be computed without overflow: shift plus (remainder != 0).
- MUL1 (exactly 16 cycles): radix-2 shift-add, tot_stores = x_rows_iter*w_cols_iter. Result fits 32 bits.
- MUL2 (exactly 16 cycles): 48-bit product P = tot_stores*x_cols_iter, iterating over x_cols_iter bits. x_tot_len = P[31:0]; ovf_o = |P[47:32].
- DONE: out_valid_o=1; all outputs stable until out_valid_o&out_ready_i, then IDLE.
  - Outputs keep their last values in IDLE; they are cleared only by reset or clear_i.
- Latency: out_valid_o rises exactly 34 cycles after the accepting edge (2 cycles for the zero-size error path).
- cfg_valid_i in any non-IDLE state is ignored (cfg_ready_o=0). No pipelining of requests.
- clear_i (any state, priority over all transitions): next cycle IDLE, out_valid_o=0, err_o=0, ovf_o=0, results zeroed.
- out_ready_i held high in advance: handshake completes in the first DONE cycle. A new request may be accepted the following cycle.
- Reset asserted mid-MUL: immediate return to the reset state. No partial results are visible.

Test Plan:
- Defaults, FP16 (fmt=1), M=20, N=33, K=40 → after 34 cycles:
  - x_rows_iter=3, x_rows_lftovr=4
  - x_cols_iter=3, x_cols_lftovr=1
  - w_rows_iter=5, w_rows_lftovr=1
  - w_cols_iter=3, w_cols_lftovr=8
  - x_d1_stride=66, yz_d0_stride=80
  - tot_stores=9, x_tot_len=27, err=0, ovf=0
- FP8 (fmt=0), M=8, N=32, K=64 → iters 1/1/4/2, all leftovers 0, x_d1_stride=32, yz_d0_stride=64, tot_stores=2, x_tot_len=2.
- FP8, M=N=K=65535 → x_rows_iter=8192, x_cols_iter=2048, w_cols_iter=2048, tot_stores=16777216, x_tot_len=0, ovf_o=1.
- M=0, N=5, K=5 → out_valid_o after 2 cycles, err_o=1, all numeric outputs 0.
- Backpressure: out_ready_i low for 10 cycles in DONE → outputs constant, cfg_ready_o=0, second cfg_valid_i ignored. Then handshake → IDLE.
- clear_i pulse at cycle 10 of MUL1, then rst_i pulse mid-MUL2 on a new request → IDLE, outputs 0; the next request completes correctly in 34 cycles.
